// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared FSM state type, operand/result widths and dispatcher defaults.
package sqrt_pkg;
  typedef enum logic [2:0] {IDLE, START, GUARD, WAIT, OUT} state_t;
  localparam int X_W = 8;
  localparam int Y_W = 4;
  localparam int START_CYCLES_DEF = 2;
  localparam int WDOG_LIMIT = 255;
endpackage

// File: rtl/sqrt_fifo.sv
// sqrt_fifo: synchronous FIFO with async active-low reset, push/pop/full/empty/level.
module sqrt_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_q[AW-1:0]];
  always_ff @(posedge clk_i)
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      level <= '0;
    end else begin
      wr_q <= wr_q + (AW+1)'(do_push);
      rd_q <= rd_q + (AW+1)'(do_pop);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/sqrt_dispatch.sv
// sqrt_dispatch: buffers operands, sequences the sqrt unit and streams {x, y} results.
// Optional SQRT_DISPATCH_TIMEOUT_EN adds a WAIT watchdog and the timeout_o port.
module sqrt_dispatch
  import sqrt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int START_CYCLES = START_CYCLES_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [X_W-1:0] in_data_i,
  output logic           sq_start_o,
  output logic [X_W-1:0] sq_x_o,
  input  logic [1:0]     sq_busy_i,
  input  logic [Y_W-1:0] sq_y_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [X_W-1:0] out_x_o,
  output logic [Y_W-1:0] out_y_o,
  output logic [AW:0]    level_o
`ifdef SQRT_DISPATCH_TIMEOUT_EN
  , output logic         timeout_o
`endif
);
  localparam int CW = START_CYCLES > 1 ? $clog2(START_CYCLES) : 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [X_W-1:0] head;
  logic fifo_full, fifo_empty, dispatch, capture, timeout_hit;
  assign in_ready_o = rst_i && !fifo_full;
  assign dispatch = state_q == IDLE && !fifo_empty && sq_busy_i == '0;
  assign capture = state_q == WAIT && (sq_busy_i == '0 || timeout_hit);
  sqrt_fifo #(.DEPTH(DEPTH), .W(X_W)) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push(in_valid_i && in_ready_o),
    .pop(dispatch),
    .din(in_data_i),
    .dout(head),
    .full(fifo_full),
    .empty(fifo_empty),
    .level(level_o)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = dispatch ? START : IDLE;
      START: state_d = cnt_q == CW'(START_CYCLES - 1) ? GUARD : START;
      GUARD: state_d = WAIT;
      WAIT:  state_d = capture ? OUT : WAIT;
      OUT:   state_d = out_ready_i ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
`ifdef SQRT_DISPATCH_TIMEOUT_EN
  logic [7:0] wdog_q;
  // wdog_q counts consecutive busy cycles in WAIT; the limit-th one forces the result out
  assign timeout_hit = state_q == WAIT && sq_busy_i != '0 && wdog_q == 8'(WDOG_LIMIT - 1);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      wdog_q <= '0;
      timeout_o <= 1'b0;
    end else begin
      wdog_q <= (state_q == WAIT && sq_busy_i != '0) ? wdog_q + 8'd1 : '0;
      timeout_o <= state_d == OUT && (state_q == OUT ? timeout_o : timeout_hit);
    end
`else
  assign timeout_hit = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sq_start_o <= 1'b0;
      sq_x_o <= '0;
      out_valid_o <= 1'b0;
      out_x_o <= '0;
      out_y_o <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= state_q == START ? cnt_q + CW'(1) : '0;
      sq_start_o <= state_d == START;
      out_valid_o <= state_d == OUT;
      if (dispatch) sq_x_o <= head;
      if (capture) begin
        out_x_o <= sq_x_o;
        out_y_o <= timeout_hit ? '1 : sq_y_i;
      end
    end
endmodule
